// File: rtl/miner_pkg.sv
// miner_pkg: shared widths, drain FSM encoding and ack timeout for the nonce path
package miner_pkg;
  localparam int NONCE_W = 32;
  localparam int ACK_TIMEOUT = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } drain_state_t;
endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo: synchronous nonce queue with push/pop, occupancy count and synchronous clear
module nonce_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic [NONCE_W-1:0] data,
  input  logic               pop,
  output logic [NONCE_W-1:0] head,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
);
  logic [NONCE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= data;
  end
endmodule

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: collects slave nonce tickets, queues them and drains them to the serial core.
// Define NONCE_DEDUP_EN to silently drop a granted nonce equal to the last one queued.
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int SLAVES = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int PW = SLAVES > 1 ? $clog2(SLAVES) : 1,
  localparam int TW = $clog2(ACK_TIMEOUT) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SLAVES-1:0]         slave_tickets,
  input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
  input  logic                      flush,
  input  logic                      serial_busy,
  output logic                      serial_send,
  output logic [NONCE_W-1:0]        golden_nonce,
  output logic                      new_nonce,
  output logic [CW-1:0]             fifo_count,
  output logic [DROP_W-1:0]         drop_count
);
  logic [SLAVES-1:0] tickets_q, pend_valid, new_slot, grant, overwrite;
  logic [NONCE_W-1:0] pend_nonce [SLAVES];
  logic [NONCE_W-1:0] gnt_nonce, fifo_head;
  logic [PW-1:0] ptr, gnt_idx, idx;
  logic any_grant, take, dup, push, pop, full_drop, fifo_full, fifo_empty;
  logic [3:0] drops;
  logic [DROP_W:0] drop_sum;
  logic [TW-1:0] ack_cnt;
  drain_state_t state, state_n;

  assign new_slot = slave_tickets & ~tickets_q;

  // Scan from the pointer outwards; the last hit in a descending scan is the nearest request.
  always_comb begin
    any_grant = 1'b0;
    gnt_idx = ptr;
    idx = ptr;
    for (int k = SLAVES - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % SLAVES);
      if (pend_valid[idx]) begin
        any_grant = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign take      = any_grant & ~flush;
  assign grant     = take ? (SLAVES'(1) << gnt_idx) : '0;
  assign gnt_nonce = pend_nonce[gnt_idx];
  assign push      = take & ~dup & (~fifo_full | pop);
  assign full_drop = take & ~dup & fifo_full & ~pop;
  assign new_nonce = push;
  assign overwrite = new_slot & pend_valid & ~grant;
  assign drops     = 4'($countones(overwrite)) + 4'(full_drop);
  assign drop_sum  = {1'b0, drop_count} + (DROP_W + 1)'(drops);

`ifdef NONCE_DEDUP_EN
  logic [NONCE_W-1:0] last_written;
  logic last_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_written <= '0;
      last_valid   <= 1'b0;
    end else if (flush) begin
      last_valid <= 1'b0;
    end else if (push) begin
      last_written <= gnt_nonce;
      last_valid   <= 1'b1;
    end
  end
  assign dup = last_valid && (gnt_nonce == last_written);
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickets_q  <= '0;
      pend_valid <= '0;
      ptr        <= '0;
      drop_count <= '0;
    end else begin
      tickets_q  <= slave_tickets;
      pend_valid <= flush ? '0 : (pend_valid & ~grant) | new_slot;
      if (take) ptr <= (gnt_idx == PW'(SLAVES - 1)) ? '0 : gnt_idx + PW'(1);
      if (!flush) drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  // Pending payloads are qualified by pend_valid, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLAVES; i++)
      if (new_slot[i]) pend_nonce[i] <= slave_nonces[NONCE_W*i +: NONCE_W];
  end

  nonce_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .data  (gnt_nonce),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      golden_nonce <= '0;
      ack_cnt      <= '0;
    end else begin
      state   <= state_n;
      ack_cnt <= (state == ACK) ? ack_cnt + TW'(1) : '0;
      if (pop) golden_nonce <= fifo_head;
    end
  end

  // A flush wins over a same-cycle pop so no discarded word starts transmitting.
  always_comb begin
    state_n = state;
    pop = 1'b0;
    serial_send = 1'b0;
    case (state)
      IDLE: begin
        pop = ~fifo_empty & ~flush;
        state_n = pop ? SEND : IDLE;
      end
      SEND: begin
        serial_send = 1'b1;
        state_n = ACK;
      end
      ACK:  state_n = (serial_busy || ack_cnt == TW'(ACK_TIMEOUT - 1)) ? DONE : ACK;
      DONE: state_n = serial_busy ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
